sc_fetch_unit: RTL and testbench



---
 rtl/sc_fetch_unit.sv | 129 ++++++++++++
 tb/tb_sc_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_fetch_unit.sv
// PC register, next-PC select and instruction-fetch sequencer (IDLE -> REQ -> EXEC loop).
// Latency: >= 2 cycles per instruction; first commit no earlier than the 3rd cycle after reset.
// Backpressure: imem_ack stalls REQ (bounded by TIMEOUT), hold stalls EXEC indefinitely.
module sc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 8
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  pcsource,
    input  logic [31:0] br_offset,
    input  logic [31:0] jr_target,
    input  logic        hold,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_EXEC = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        imem_req_q, imem_req_d;
    logic        inst_valid_q, inst_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] pc4_w;
    logic [31:0] npc;

    assign pc4_w = pc_q + 32'd4;

    always_comb begin
        npc = pc4_w;
        case (pcsource)
            2'd0: npc = pc4_w;
            2'd1: npc = pc4_w + (br_offset << 2);
            2'd2: npc = jr_target;
            2'd3: npc = {pc4_w[31:28], inst_q[25:0], 2'b00};
            default: npc = pc4_w;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                cnt_d   = 8'd0;
            end
            S_REQ: begin
                // A same-cycle ack takes priority over the timeout firing.
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    cnt_d   = 8'd0;
                    state_d = S_EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EXEC: begin
                if (!hold) begin
                    if (npc[1:0] != 2'b00) begin
                        state_d = S_ERR;
                    end else begin
                        pc_d    = npc;
                        state_d = S_REQ;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: state_d = S_ERR;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        imem_req_d   = (state_d == S_REQ);
        inst_valid_d = (state_d == S_EXEC);
        fetch_err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= 32'd0;
            cnt_q        <= 8'd0;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            cnt_q        <= cnt_d;
            imem_req_q   <= imem_req_d;
            inst_valid_q <= inst_valid_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign pc4        = pc4_w;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_sc_fetch_unit.sv
// Bench for sc_fetch_unit: directed vector table, hand-written corner sequences,
// then randomized instruction stream checked against an instruction-level model.
module tb_sc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TO     = 8;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [1:0]  pcsource;
    logic [31:0] br_offset;
    logic [31:0] jr_target;
    logic        hold;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_err;

    sc_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pcsource   (pcsource),
        .br_offset  (br_offset),
        .jr_target  (jr_target),
        .hold       (hold),
        .pc         (pc),
        .pc4        (pc4),
        .inst       (inst),
        .inst_valid (inst_valid),
        .fetch_err  (fetch_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_inst;

    typedef struct {
        int          delay;
        int          holds;
        logic [31:0] word;
        logic [1:0]  src;
        logic [31:0] off;
        logic [31:0] jr;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Next PC from the architectural rules, in plain arithmetic.
    function automatic logic [31:0] ref_npc(input logic [31:0] cur_pc, input logic [31:0] cur_inst,
                                            input logic [1:0] src, input logic [31:0] off,
                                            input logic [31:0] jr);
        logic [31:0] nxt;
        nxt = cur_pc + 32'd4;
        case (src)
            2'd0:    return nxt;
            2'd1:    return nxt + off * 32'd4;
            2'd2:    return jr;
            default: return (nxt & 32'hF000_0000) | ((cur_inst & 32'h03FF_FFFF) * 32'd4);
        endcase
    endfunction

    task automatic do_reset;
        reset    = 1'b1;
        imem_ack = 1'b0;
        hold     = 1'b0;
        tick;
        tick;
        chk("rst_pc", pc, RST_PC);
        chk("rst_inst", inst, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        reset = 1'b0;
        tick;
        m_pc = RST_PC;
    endtask

    // Entered in the first REQ cycle; leaves in the first EXEC cycle.
    task automatic fetch(input int delay, input logic [31:0] word);
        chk("req_start", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, m_pc);
        for (int i = 0; i < delay; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            tick;
            chk("req_wait", {31'd0, imem_req}, 32'd1);
            chk("req_wait_addr", imem_addr, m_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick;
        imem_ack = 1'b0;
        m_inst   = word;
        chk("exec_valid", {31'd0, inst_valid}, 32'd1);
        chk("exec_inst", inst, word);
        chk("exec_req", {31'd0, imem_req}, 32'd0);
        chk("exec_pc", pc, m_pc);
    endtask

    task automatic exec(input int holds, input logic [1:0] src, input logic [31:0] off,
                        input logic [31:0] jr, input logic [31:0] exp_pc, input logic exp_err);
        int commits;
        commits   = 0;
        pcsource  = src;
        br_offset = off;
        jr_target = jr;
        for (int i = 0; i < holds; i++) begin
            hold       = 1'b1;
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            if (inst_valid && !hold) commits++;
            tick;
            chk("hold_valid", {31'd0, inst_valid}, 32'd1);
            chk("hold_inst", inst, m_inst);
            chk("hold_pc", pc, m_pc);
        end
        hold     = 1'b0;
        imem_ack = 1'b0;
        if (inst_valid && !hold) commits++;
        tick;
        chk("commits", commits, 32'd1);
        chk("post_valid", {31'd0, inst_valid}, 32'd0);
        if (exp_err) begin
            chk("mis_err", {31'd0, fetch_err}, 32'd1);
            chk("mis_req", {31'd0, imem_req}, 32'd0);
            chk("mis_pc", pc, m_pc);
        end else begin
            chk("next_req", {31'd0, imem_req}, 32'd1);
            chk("next_pc", pc, exp_pc);
            chk("next_addr", imem_addr, exp_pc);
            chk("no_err", {31'd0, fetch_err}, 32'd0);
            m_pc = exp_pc;
        end
    endtask

    task automatic check_err_sticky;
        for (int i = 0; i < 3; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            tick;
            chk("err_sticky", {31'd0, fetch_err}, 32'd1);
            chk("err_noreq", {31'd0, imem_req}, 32'd0);
            chk("err_novalid", {31'd0, inst_valid}, 32'd0);
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0, 0, 32'h0000_0020, 2'd0, 32'd0,         32'd0,         32'h0000_0004, 1'b0};
        vecs[1] = '{0, 0, 32'h0000_0021, 2'd0, 32'd0,         32'd0,         32'h0000_0008, 1'b0};
        vecs[2] = '{0, 0, 32'h0000_0022, 2'd2, 32'd0,         32'h0000_0010, 32'h0000_0010, 1'b0};
        vecs[3] = '{1, 0, 32'h1000_FFFE, 2'd1, 32'hFFFF_FFFE, 32'd0,         32'h0000_000C, 1'b0};
        vecs[4] = '{0, 0, 32'h0000_0008, 2'd2, 32'd0,         32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        vecs[5] = '{0, 0, 32'h0000_0000, 2'd0, 32'd0,         32'd0,         32'h0000_0000, 1'b0};
        vecs[6] = '{2, 5, 32'h0000_0008, 2'd2, 32'd0,         32'h1000_0000, 32'h1000_0000, 1'b0};
        vecs[7] = '{7, 0, 32'h0800_0040, 2'd3, 32'd0,         32'd0,         32'h1000_0100, 1'b0};
        vecs[8] = '{3, 1, 32'h1000_0010, 2'd1, 32'h0000_0010, 32'd0,         32'h1000_0144, 1'b0};
        vecs[9] = '{0, 0, 32'h0000_0008, 2'd2, 32'd0,         32'h0000_0022, 32'h1000_0144, 1'b1};

        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        pcsource   = 2'd0;
        br_offset  = 32'd0;
        jr_target  = 32'd0;
        hold       = 1'b0;
        m_pc       = RST_PC;
        m_inst     = 32'd0;

        do_reset;
        for (int i = 0; i < 10; i++) begin
            fetch(vecs[i].delay, vecs[i].word);
            exec(vecs[i].holds, vecs[i].src, vecs[i].off, vecs[i].jr, vecs[i].exp_pc, vecs[i].exp_err);
        end
        check_err_sticky;

        // Fetch timeout: no ack for TO REQ cycles.
        do_reset;
        for (int k = 0; k < TO; k++) begin
            chk("to_req", {31'd0, imem_req}, 32'd1);
            imem_ack = 1'b0;
            tick;
        end
        chk("to_err", {31'd0, fetch_err}, 32'd1);
        chk("to_req_off", {31'd0, imem_req}, 32'd0);
        chk("to_pc", pc, RST_PC);
        check_err_sticky;

        // Reset while in REQ with a simultaneous ack: ack must be discarded.
        do_reset;
        fetch(0, 32'h1234_5678);
        exec(0, 2'd0, 32'd0, 32'd0, RST_PC + 32'd4, 1'b0);
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick;
        reset    = 1'b0;
        imem_ack = 1'b0;
        chk("rreq_pc", pc, RST_PC);
        chk("rreq_inst", inst, 32'd0);
        chk("rreq_req", {31'd0, imem_req}, 32'd0);
        chk("rreq_valid", {31'd0, inst_valid}, 32'd0);
        tick;
        chk("rreq_refetch", {31'd0, imem_req}, 32'd1);
        chk("rreq_inst2", inst, 32'd0);
        m_pc = RST_PC;

        // Randomized instruction stream against the model.
        for (int n = 0; n < 300; n++) begin
            int          delay;
            int          holds;
            logic [1:0]  src;
            logic [31:0] off;
            logic [31:0] jr;
            logic [31:0] word;
            logic [31:0] npc;
            logic        err;
            delay = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO - 1)) : 0;
            holds = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            src   = 2'($urandom_range(0, 3));
            off   = 32'($urandom_range(0, 255)) - 32'd128;
            jr    = ($urandom_range(0, 11) == 0) ? ($urandom | 32'd1) : ($urandom & 32'hFFFF_FFFC);
            word  = $urandom;
            if ($urandom_range(0, 39) == 0) begin
                for (int k = 0; k < TO; k++) begin
                    chk("rto_req", {31'd0, imem_req}, 32'd1);
                    imem_ack = 1'b0;
                    tick;
                end
                chk("rto_err", {31'd0, fetch_err}, 32'd1);
                chk("rto_pc", pc, m_pc);
                do_reset;
            end else begin
                npc = ref_npc(m_pc, word, src, off, jr);
                err = (npc % 4) != 0;
                fetch(delay, word);
                exec(holds, src, off, jr, npc, err);
                if (err) do_reset;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
